conv_pass_sequencer: RTL and testbench

//  FSM that runs one full convolution pass over the PE array. It drives the
//  EN_K / EN_I / EN_O_In / EN_O_Out strobes of the PE edge address controller.
//  Per pass: load weights once, then run BlockCount blocks.

---
 rtl/conv_pass_sequencer.sv | 148 ++++++++++++++
 tb/tb_conv_pass_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pass_sequencer.sv
// Convolution pass sequencer: loads weights once, then streams/waits/drains BlockCount blocks,
// driving the PE edge-controller enable strobes as Mealy handshake outputs.
module conv_pass_sequencer #(
  parameter int unsigned K_PEGroupSize   = 4,
  parameter int unsigned O_PEGroupSize   = 4,
  parameter int unsigned I_PEGroupSize   = 7,
  parameter int unsigned BlockCount      = 4,
  parameter int unsigned BlockCountWidth = 3,
  parameter int unsigned PipeLatency     = 2,
  parameter int unsigned CntWidth        = 4
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       i_sclr,
  input  logic                       i_start,
  input  logic                       i_in_valid,
  input  logic                       i_out_ready,
  output logic                       o_en_k,
  output logic                       o_en_i,
  output logic                       o_en_o_in,
  output logic                       o_en_o_out,
  output logic [BlockCountWidth-1:0] o_block_idx,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [2:0] {StIdle, StLoadK, StStream, StWait, StDrain, StDone} state_e;

  localparam int unsigned WaitLastInt = (PipeLatency > 0) ? PipeLatency - 1 : 0;

  localparam logic [CntWidth-1:0]        KLast    = CntWidth'(K_PEGroupSize - 1);
  localparam logic [CntWidth-1:0]        ILast    = CntWidth'(I_PEGroupSize - 1);
  localparam logic [CntWidth-1:0]        OLast    = CntWidth'(O_PEGroupSize - 1);
  localparam logic [CntWidth-1:0]        WaitLast = CntWidth'(WaitLastInt);
  localparam logic [BlockCountWidth-1:0] BlkLast  = BlockCountWidth'(BlockCount - 1);

  state_e                     r_state, w_state_d;
  logic [CntWidth-1:0]        r_beat, w_beat_d;
  logic [CntWidth-1:0]        r_wait, w_wait_d;
  logic [BlockCountWidth-1:0] r_blk, w_blk_d;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state <= StIdle;
      r_beat  <= '0;
      r_wait  <= '0;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_d;
      r_beat  <= w_beat_d;
      r_wait  <= w_wait_d;
      r_blk   <= w_blk_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_beat_d   = r_beat;
    w_wait_d   = r_wait;
    w_blk_d    = r_blk;
    o_en_k     = 1'b0;
    o_en_i     = 1'b0;
    o_en_o_in  = 1'b0;
    o_en_o_out = 1'b0;

    // A synchronous clear abandons the pass and suppresses this cycle's strobes.
    if (i_sclr) begin
      w_state_d = StIdle;
      w_beat_d  = '0;
      w_wait_d  = '0;
      w_blk_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_d = StLoadK;
            w_beat_d  = '0;
          end
        end
        StLoadK: begin
          o_en_k = i_in_valid;
          if (i_in_valid) begin
            if (r_beat == KLast) begin
              w_state_d = StStream;
              w_beat_d  = '0;
              w_blk_d   = '0;
            end else begin
              w_beat_d = r_beat + CntWidth'(1);
            end
          end
        end
        StStream: begin
          o_en_i    = i_in_valid;
          o_en_o_in = i_in_valid && (r_beat >= KLast);
          if (i_in_valid) begin
            if (r_beat == ILast) begin
              w_state_d = (PipeLatency > 0) ? StWait : StDrain;
              w_beat_d  = '0;
              w_wait_d  = '0;
            end else begin
              w_beat_d = r_beat + CntWidth'(1);
            end
          end
        end
        StWait: begin
          if (r_wait == WaitLast) begin
            w_state_d = StDrain;
            w_wait_d  = '0;
            w_beat_d  = '0;
          end else begin
            w_wait_d = r_wait + CntWidth'(1);
          end
        end
        StDrain: begin
          o_en_o_out = i_out_ready;
          if (i_out_ready) begin
            if (r_beat == OLast) begin
              w_beat_d = '0;
              if (r_blk == BlkLast) begin
                w_state_d = StDone;
              end else begin
                w_blk_d   = r_blk + BlockCountWidth'(1);
                w_state_d = StStream;
              end
            end else begin
              w_beat_d = r_beat + CntWidth'(1);
            end
          end
        end
        StDone: begin
          w_state_d = StIdle;
          w_blk_d   = '0;
        end
        default: begin
          w_state_d = StIdle;
          w_beat_d  = '0;
          w_wait_d  = '0;
          w_blk_d   = '0;
        end
      endcase
    end
  end

  assign o_block_idx = r_blk;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Directed bench for conv_pass_sequencer: expected output vectors are queued per cycle and
// popped against the DUT at the falling edge.
module tb_conv_pass_sequencer;

  logic clk = 1'b0;
  logic aclr, sclr, start, start6, in_valid, out_ready;

  logic       en_k, en_i, en_o_in, en_o_out, busy, done;
  logic [2:0] blk;
  logic       en_k6, en_i6, en_o_in6, en_o_out6, busy6, done6;
  logic [0:0] blk6;

  always #5 clk = ~clk;

  conv_pass_sequencer dut (
    .clk        (clk),
    .aclr       (aclr),
    .i_sclr     (sclr),
    .i_start    (start),
    .i_in_valid (in_valid),
    .i_out_ready(out_ready),
    .o_en_k     (en_k),
    .o_en_i     (en_i),
    .o_en_o_in  (en_o_in),
    .o_en_o_out (en_o_out),
    .o_block_idx(blk),
    .o_busy     (busy),
    .o_done     (done)
  );

  conv_pass_sequencer #(
    .BlockCount     (1),
    .BlockCountWidth(1),
    .PipeLatency    (0)
  ) dut6 (
    .clk        (clk),
    .aclr       (aclr),
    .i_sclr     (sclr),
    .i_start    (start6),
    .i_in_valid (in_valid),
    .i_out_ready(out_ready),
    .o_en_k     (en_k6),
    .o_en_i     (en_i6),
    .o_en_o_in  (en_o_in6),
    .o_en_o_out (en_o_out6),
    .o_block_idx(blk6),
    .o_busy     (busy6),
    .o_done     (done6)
  );

  // Vector layout: [8]en_k [7]en_i [6]en_o_in [5]en_o_out [4]busy [3]done [2:0]block_idx
  logic [31:0] obs0, obs6;
  assign obs0 = {23'd0, en_k, en_i, en_o_in, en_o_out, busy, done, blk};
  assign obs6 = {23'd0, en_k6, en_i6, en_o_in6, en_o_out6, busy6, done6, 2'b00, blk6};

  typedef struct {
    string       tag;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected vector at cycle c of a pass started at cycle 0 with in_valid=out_ready=1.
  function automatic logic [31:0] tl_vec(int c, int k, int ni, int no, int lat, int nblk);
    logic [31:0] v;
    int s, l, b, off;
    v = '0;
    s = 1 + k;
    l = ni + lat + no;
    if (c >= 1 && c <= k) v[8] = 1'b1;
    if (c >= 1 && c <= s + nblk * l) v[4] = 1'b1;
    if (c >= s && c < s + nblk * l) begin
      b   = (c - s) / l;
      off = (c - s) % l;
      v[2:0] = 3'(b);
      if (off < ni) v[7] = 1'b1;
      if (off >= k - 1 && off < ni) v[6] = 1'b1;
      if (off >= ni + lat) v[5] = 1'b1;
    end
    if (c == s + nblk * l) begin
      v[3]   = 1'b1;
      v[2:0] = 3'(nblk - 1);
    end
    return v;
  endfunction

  function automatic logic [31:0] t1(int c);
    return tl_vec(c, 4, 7, 4, 2, 4);
  endfunction

  task automatic push(input string tag, input logic [31:0] exp, input logic [31:0] mask);
    exp_t e;
    e.tag  = tag;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic drain(input logic [31:0] obs);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert ((obs & e.mask) === (e.exp & e.mask)) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h mask=%h", e.tag, obs & e.mask,
               e.exp & e.mask, e.mask);
      end
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at the following negedge.
  task automatic cyc(input logic s, input logic s6, input logic v, input logic r, input logic sc,
                     input string tag, input logic [31:0] exp, input logic [31:0] mask,
                     input bit use6);
    start     = s;
    start6    = s6;
    in_valid  = v;
    out_ready = r;
    sclr      = sc;
    push(tag, exp, mask);
    @(negedge clk);
    drain(use6 ? obs6 : obs0);
    @(posedge clk);
    #1;
  endtask

  int  nk, ni, noin, ib, nout1;
  bit  seen_done;

  initial begin
    aclr = 1'b1; sclr = 1'b0; start = 1'b0; start6 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset state of both instances
    @(negedge clk);
    push("reset_dut", '0, '1);
    drain(obs0);
    push("reset_dut6", '0, '1);
    drain(obs6);
    @(posedge clk);
    #1;
    aclr = 1'b0;

    // T1: full pass, always ready
    for (int c = 0; c <= 58; c++)
      cyc(c == 0, 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("t1_c%0d", c), t1(c), '1, 1'b0);

    // T2: in_valid low every other cycle
    nk = 0; ni = 0; noin = 0; ib = 0; seen_done = 0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      start = (c == 0); start6 = 1'b0; sclr = 1'b0; out_ready = 1'b1;
      in_valid = (c % 2 == 1);
      @(negedge clk);
      if (!in_valid) push($sformatf("t2_idle_strobe_c%0d", c), '0, 32'h1C0);
      push($sformatf("t2_en_o_in_c%0d", c), {25'd0, (en_i && ib >= 3), 6'd0}, 32'h040);
      if (en_i) ib = (ib + 1) % 7;
      if (en_k) nk++;
      if (en_i) ni++;
      if (en_o_in) noin++;
      if (done) seen_done = 1;
      drain(obs0);
      @(posedge clk);
      #1;
    end
    push("t2_done_seen", 32'd1, '1);
    drain(32'(seen_done));
    push("t2_en_k_count", 32'd4, '1);
    drain(32'(nk));
    push("t2_en_i_count", 32'd28, '1);
    drain(32'(ni));
    push("t2_en_o_in_count", 32'd16, '1);
    drain(32'(noin));

    // T3: out_ready low for 5 cycles inside block 1 drain; timeline shifts by 5 afterwards
    nout1 = 0;
    for (int c = 0; c <= 63; c++) begin
      logic [31:0] e;
      if (c < 28) e = t1(c);
      else if (c <= 32) e = 32'h011;
      else e = t1(c - 5);
      start = (c == 0); start6 = 1'b0; sclr = 1'b0; in_valid = 1'b1;
      out_ready = !(c >= 28 && c <= 32);
      push($sformatf("t3_c%0d", c), e, '1);
      @(negedge clk);
      if (en_o_out && blk == 3'd1) nout1++;
      drain(obs0);
      @(posedge clk);
      #1;
    end
    push("t3_blk1_drain_count", 32'd4, '1);
    drain(32'(nout1));

    // T4: asynchronous clear during block 2 stream, then a clean pass
    for (int c = 0; c <= 32; c++)
      cyc(c == 0, 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("t4_pre_c%0d", c), t1(c), '1, 1'b0);
    start = 1'b0;
    #1;
    push("t4_mid_stream", t1(33), '1);
    drain(obs0);
    #1;
    aclr = 1'b1;
    #1;
    push("t4_async_zero", '0, '1);
    drain(obs0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++)
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t4_held_zero", '0, '1, 1'b0);
    aclr = 1'b0;
    for (int c = 0; c <= 58; c++)
      cyc(c == 0, 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("t4_rerun_c%0d", c), t1(c), '1, 1'b0);

    // T5: start pulses while busy are ignored; sclr beats start in IDLE
    for (int c = 0; c <= 60; c++)
      cyc(c == 0 || c == 10 || c == 30 || c == 57 || c == 58, 1'b0, 1'b1, 1'b1, c == 58,
          $sformatf("t5_c%0d", c), t1(c), '1, 1'b0);

    // start held through DONE: the next pass begins from the following IDLE cycle
    for (int c = 0; c <= 59; c++)
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, $sformatf("t5_held_c%0d", c),
          (c == 59) ? t1(1) : t1(c), '1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "t5_sclr_busy", 32'h010, 32'h018, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t5_sclr_idle", '0, '1, 1'b0);

    // T6: single block, no pipeline wait
    for (int c = 0; c <= 18; c++)
      cyc(1'b0, c == 0, 1'b1, 1'b1, 1'b0, $sformatf("t6_c%0d", c),
          tl_vec(c, 4, 7, 4, 0, 1), '1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
